// File: rtl/apb_master.sv
// APB master: turns a single-outstanding command/response handshake into
// APB SETUP/ACCESS transfers. Each transfer can be ended early by an optional
// wait-state timeout.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer; cmd_ready=1, a command is accepted on cmd_valid
// SETUP  | psel=1, penable=0, address/control/data presented (one cycle)
// ACCESS | psel=1, penable=1, waiting for pready or for the timeout
// RESP   | response held on rsp_* until rsp_ready
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata
);

    // Counter is one value wider than the limit needs so that, with the
    // timeout disabled, it still has headroom before it saturates.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic                    timeout_hit;

    // Expiry is judged on the registered count, so pready arriving in the
    // expiry cycle still completes the transfer normally.
    assign timeout_hit = TIMEOUT_EN && (wait_cnt_q >= CNT_LIMIT);

    // Register all state, APB outputs and response outputs; reset clears them.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d   = cmd_write;
                    paddr_d    = cmd_addr;
                    pwdata_d   = cmd_wdata;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_SETUP;
                end
            end

            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end

            S_ACCESS: begin
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    state_d     = S_RESP;
                end else if (timeout_hit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed corner transfers plus randomized transfers,
// checked against a per-transaction expectation derived from the wait count.
module tb_apb_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [AW-1:0] last_addr;

    apb_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .prdata    (prdata)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Noise on inputs the DUT must ignore in the current phase.
    task automatic scramble_cmd();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
    endtask

    task automatic scramble_apb();
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
    endtask

    // One full transfer, entered and left just after a falling edge with the
    // DUT idle. waits = pready-low ACCESS cycles before the completer answers.
    task automatic txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int waits, input bit slv, input logic [DW-1:0] rd,
                       input int rdly);
        bit            tmo;
        int            exp_acc;
        bit            exp_err;
        logic [DW-1:0] exp_rdata;
        bit            hit;

        tmo       = (waits > TMO);
        exp_acc   = tmo ? TMO + 1 : waits + 1;
        exp_err   = tmo ? 1'b1 : slv;
        exp_rdata = (tmo || w) ? '0 : rd;

        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_psel", psel, 0);
        chk("idle_penable", penable, 0);
        chk("idle_paddr_kept", paddr, last_addr);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = wd;
        scramble_apb();

        @(negedge pclk);
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", pwrite, w);
        chk("setup_pwdata", pwdata, wd);
        chk("setup_cmd_ready", cmd_ready, 0);
        chk("setup_rsp_valid", rsp_valid, 0);
        scramble_cmd();
        scramble_apb();

        for (int k = 0; k < exp_acc; k++) begin
            @(negedge pclk);
            chk("access_psel", psel, 1);
            chk("access_penable", penable, 1);
            chk("access_paddr", paddr, a);
            chk("access_pwrite", pwrite, w);
            chk("access_pwdata", pwdata, wd);
            chk("access_rsp_valid", rsp_valid, 0);
            hit = !tmo && (k == waits);
            pready  = hit;
            pslverr = hit ? slv : 1'($urandom_range(0, 1));
            prdata  = hit ? rd : $urandom;
            scramble_cmd();
        end

        @(negedge pclk);
        last_addr = a;
        for (int r = 0; r <= rdly; r++) begin
            chk("resp_valid", rsp_valid, 1);
            chk("resp_err", rsp_err, exp_err);
            chk("resp_rdata", rsp_rdata, exp_rdata);
            chk("resp_psel", psel, 0);
            chk("resp_penable", penable, 0);
            chk("resp_cmd_ready", cmd_ready, 0);
            rsp_ready = (r == rdly);
            scramble_apb();
            scramble_cmd();
            @(negedge pclk);
        end

        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        pready    = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            scramble_apb();
            @(negedge pclk);
            chk("gap_psel", psel, 0);
            chk("gap_cmd_ready", cmd_ready, 1);
            chk("gap_rsp_valid", rsp_valid, 0);
        end
    endtask

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        last_addr = '0;

        repeat (3) @(negedge pclk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        preset = 1'b0;
        @(negedge pclk);
        chk("rst_cmd_ready", cmd_ready, 1);

        // Minimum-latency write, wait-stated read, timeout, pready at expiry,
        // slave error with a stalled response consumer.
        txn(1'b1, 32'h0,  32'h1, 0, 1'b0, 32'h0,        0);
        txn(1'b0, 32'h0,  32'h0, 3, 1'b0, 32'h00000001, 0);
        txn(1'b0, 32'h10, 32'h0, 9, 1'b0, 32'h55,       0);
        txn(1'b0, 32'h14, 32'h0, 4, 1'b1, 32'h77,       1);
        txn(1'b1, 32'h18, 32'hA, 4, 1'b0, 32'h0,        0);
        txn(1'b0, 32'h20, 32'h0, 0, 1'b1, 32'hDEADBEEF, 5);
        idle_gap(2);

        for (int t = 0; t < 40; t++) begin
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1)
                idle_gap(int'($urandom_range(1, 3)));
        end

        // Reset while the transfer sits in ACCESS: it must vanish silently.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        cmd_wdata = 32'h0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        @(negedge pclk);
        chk("abort_in_access", penable, 1);
        preset = 1'b1;
        @(negedge pclk);
        chk("abort_psel", psel, 0);
        chk("abort_penable", penable, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_paddr", paddr, 0);
        preset  = 1'b0;
        pready  = 1'b1;
        pslverr = 1'b1;
        last_addr = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("abort_cmd_ready", cmd_ready, 1);
            chk("abort_no_rsp", rsp_valid, 0);
            chk("abort_psel_idle", psel, 0);
        end
        pready = 1'b0;

        txn(1'b0, 32'h44, 32'h0, 2, 1'b0, 32'h12345678, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
